// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address width, reset vector and the PC operation encoding.
package cpu_pkg;

    localparam int unsigned ADDR_W = 9;
    localparam logic [ADDR_W-1:0] RESET_PC = 9'h000;

    // Resolved per-cycle program-counter operation.
    typedef enum logic [2:0] {
        PC_INC,
        PC_LOAD,
        PC_CALL,
        PC_RET,
        PC_SWAP
    } pc_op_t;

endpackage

// File: rtl/pc_stack_unit_ret_stack.sv
// Return-address LIFO: push, pop and swap-top, with its own over/underflow guards.
// The top entry is read combinationally so the PC can take it in the same cycle.
module ret_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       swap,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     sp,
    output logic                       full,
    output logic                       empty
);
    import cpu_pkg::*;

    localparam int unsigned IW   = $clog2(DEPTH);
    localparam int unsigned SP_W = IW + 1;

    logic [W-1:0]    mem [DEPTH];
    logic [SP_W-1:0] sp_reg;
    logic [SP_W-1:0] sp_next;
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   top_idx;
    logic            push_ok;
    logic            pop_ok;
    logic            swap_ok;

    assign full    = (sp_reg == SP_W'(DEPTH));
    assign empty   = (sp_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign swap_ok = swap && !empty;
    assign wr_idx  = sp_reg[IW-1:0];
    assign top_idx = IW'(sp_reg - SP_W'(1));
    assign rdata   = mem[top_idx];
    assign sp      = sp_reg;

    // Occupancy change: push and pop are never both requested by the top.
    always_comb begin
        sp_next = sp_reg;
        if (push_ok)
            sp_next = sp_reg + SP_W'(1);
        else if (pop_ok)
            sp_next = sp_reg - SP_W'(1);
    end

    // Occupancy register; contents beyond sp are unreachable so only sp is reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sp_reg <= '0;
        else
            sp_reg <= sp_next;
    end

    // Entry storage: push writes above the top, swap overwrites the top in place.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_idx] <= wdata;
        else if (swap_ok)
            mem[top_idx] <= wdata;
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with call/return stack. Decodes the control strobes into a
// single operation, then updates pc, the return stack and the sticky error flags.
module pc_stack_unit #(
    parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [ADDR_W-1:0]       load_addr,
    input  logic                    call,
    input  logic                    ret,
    output logic [ADDR_W-1:0]       pc,
    output logic [$clog2(DEPTH):0]  sp,
    output logic                    stack_full,
    output logic                    stack_empty,
    output logic                    err_ovf,
    output logic                    err_unf
);
    import cpu_pkg::*;

    pc_op_t             op;
    logic [ADDR_W-1:0]  pc_reg;
    logic [ADDR_W-1:0]  pc_next;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  top_data;
    logic               push;
    logic               pop;
    logic               swap;
    logic               full;
    logic               empty;
    logic               ovf_reg;
    logic               ovf_next;
    logic               unf_reg;
    logic               unf_next;

    assign pc_inc = pc_reg + ADDR_W'(1);

    // Priority decode; call&ret on an empty stack degrades to a plain underflowing ret.
    always_comb begin
        op = PC_INC;
        if (call && ret)
            op = empty ? PC_RET : PC_SWAP;
        else if (ret)
            op = PC_RET;
        else if (call)
            op = PC_CALL;
        else if (load)
            op = PC_LOAD;
    end

    // Next pc, stack commands and error-flag set conditions; en=0 freezes everything.
    always_comb begin
        pc_next  = pc_reg;
        push     = 1'b0;
        pop      = 1'b0;
        swap     = 1'b0;
        ovf_next = ovf_reg;
        unf_next = unf_reg;
        if (en) begin
            case (op)
                PC_LOAD: pc_next = load_addr;
                PC_CALL: begin
                    if (full) begin
                        pc_next  = pc_inc;
                        ovf_next = 1'b1;
                    end else begin
                        pc_next = load_addr;
                        push    = 1'b1;
                    end
                end
                PC_RET: begin
                    if (empty) begin
                        pc_next  = pc_inc;
                        unf_next = 1'b1;
                    end else begin
                        pc_next = top_data;
                        pop     = 1'b1;
                    end
                end
                PC_SWAP: begin
                    pc_next = top_data;
                    swap    = 1'b1;
                end
                default: pc_next = pc_inc;
            endcase
        end
    end

    // Program counter and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg  <= RESET_PC;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            pc_reg  <= pc_next;
            ovf_reg <= ovf_next;
            unf_reg <= unf_next;
        end
    end

    ret_stack #(
        .DEPTH (DEPTH),
        .W     (ADDR_W)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .swap  (swap),
        .wdata (pc_inc),
        .rdata (top_data),
        .sp    (sp),
        .full  (full),
        .empty (empty)
    );

    assign pc          = pc_reg;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign err_ovf     = ovf_reg;
    assign err_unf     = unf_reg;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed test of pc_stack_unit: sequencing, jumps, call/return, stack limits,
// swap, enable hold and asynchronous reset.
module tb_pc_stack_unit;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [8:0] load_addr;
    logic       call;
    logic       ret;
    logic [8:0] pc;
    logic [2:0] sp;
    logic       stack_full;
    logic       stack_empty;
    logic       err_ovf;
    logic       err_unf;

    int n_vec;
    int n_err;

    pc_stack_unit #(
        .ADDR_W   (9),
        .DEPTH    (4),
        .RESET_PC (9'h000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .load_addr   (load_addr),
        .call        (call),
        .ret         (ret),
        .pc          (pc),
        .sp          (sp),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .err_ovf     (err_ovf),
        .err_unf     (err_unf)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Apply one cycle of control, then settle 1 ns past the edge.
    task automatic step(input logic e, input logic c, input logic r,
                        input logic l, input logic [8:0] a);
        en        = e;
        call      = c;
        ret       = r;
        load      = l;
        load_addr = a;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        en        = 1'b0;
        load      = 1'b0;
        load_addr = '0;
        call      = 1'b0;
        ret       = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_pc", pc, 9'h000);
        check("rst_sp", sp, 3'd0);
        check("rst_empty", stack_empty, 1'b1);
        check("rst_full", stack_full, 1'b0);
        check("rst_ovf", err_ovf, 1'b0);
        check("rst_unf", err_unf, 1'b0);

        // 1: plain increment
        step(1, 0, 0, 0, 9'h000); check("inc1_pc", pc, 9'h001);
        step(1, 0, 0, 0, 9'h000); check("inc2_pc", pc, 9'h002);
        step(1, 0, 0, 0, 9'h000); check("inc3_pc", pc, 9'h003);
        check("inc_sp", sp, 3'd0);
        check("inc_empty", stack_empty, 1'b1);

        // 2: load, then wrap at 1FF
        step(1, 0, 0, 0, 9'h000);
        step(1, 0, 0, 0, 9'h000); check("pre_load_pc", pc, 9'h005);
        step(1, 0, 0, 1, 9'h1A0); check("load_pc", pc, 9'h1A0);
        step(1, 0, 0, 1, 9'h1FF); check("load_1ff", pc, 9'h1FF);
        step(1, 0, 0, 0, 9'h123); check("wrap_pc", pc, 9'h000);
        check("wrap_ovf", err_ovf, 1'b0);
        check("wrap_unf", err_unf, 1'b0);

        // 3: nested call / return
        step(1, 0, 0, 1, 9'h010); check("c3_start", pc, 9'h010);
        step(1, 1, 0, 0, 9'h080); check("call1_pc", pc, 9'h080); check("call1_sp", sp, 3'd1);
        step(1, 0, 0, 0, 9'h000); check("c3_inc", pc, 9'h081);
        step(1, 1, 0, 0, 9'h0C0); check("call2_pc", pc, 9'h0C0); check("call2_sp", sp, 3'd2);
        step(1, 0, 1, 1, 9'h1AB); check("ret1_pc", pc, 9'h082); check("ret1_sp", sp, 3'd1);
        step(1, 0, 1, 0, 9'h000); check("ret2_pc", pc, 9'h011); check("ret2_sp", sp, 3'd0);

        // 4: overflow with DEPTH=4
        step(1, 1, 0, 0, 9'h100); check("ov_c1_sp", sp, 3'd1);
        step(1, 1, 0, 0, 9'h110); check("ov_c2_sp", sp, 3'd2);
        step(1, 1, 0, 0, 9'h120); check("ov_c3_sp", sp, 3'd3);
        check("ov_not_full", stack_full, 1'b0);
        step(1, 1, 0, 0, 9'h130); check("ov_c4_pc", pc, 9'h130); check("ov_c4_sp", sp, 3'd4);
        check("ov_full", stack_full, 1'b1);
        check("ov_no_err_yet", err_ovf, 1'b0);
        step(1, 1, 0, 0, 9'h140); check("ov_c5_pc", pc, 9'h131); check("ov_c5_sp", sp, 3'd4);
        check("ov_flag", err_ovf, 1'b1);
        step(1, 0, 1, 0, 9'h000); check("ov_ret_pc", pc, 9'h121); check("ov_ret_sp", sp, 3'd3);
        check("ov_sticky", err_ovf, 1'b1);

        // 4b: underflow after reset
        en = 1'b0; call = 1'b0; ret = 1'b0;
        pulse_reset();
        check("rr_ovf_clr", err_ovf, 1'b0);
        check("rr_sp", sp, 3'd0);
        step(1, 0, 1, 0, 9'h000); check("unf_pc", pc, 9'h001); check("unf_sp", sp, 3'd0);
        check("unf_flag", err_unf, 1'b1);

        // 5: swap (call&ret) and enable hold
        step(1, 0, 0, 1, 9'h03F);
        step(1, 1, 0, 0, 9'h100); check("sw_pre_pc", pc, 9'h100); check("sw_pre_sp", sp, 3'd1);
        step(1, 1, 1, 1, 9'h1EE); check("swap_pc", pc, 9'h040); check("swap_sp", sp, 3'd1);
        step(0, 1, 0, 0, 9'h055); check("hold_pc", pc, 9'h040); check("hold_sp", sp, 3'd1);
        step(0, 1, 1, 1, 9'h055); check("hold2_pc", pc, 9'h040);
        step(1, 0, 1, 0, 9'h000); check("swap_top_pc", pc, 9'h101); check("swap_top_sp", sp, 3'd0);
        step(1, 1, 1, 0, 9'h077); check("swap_empty_pc", pc, 9'h102); check("swap_empty_sp", sp, 3'd0);
        check("swap_empty_unf", err_unf, 1'b1);

        // 6: asynchronous reset in the middle of a call, sp=2
        step(1, 1, 0, 0, 9'h050);
        step(1, 1, 0, 0, 9'h060); check("ar_pre_sp", sp, 3'd2); check("ar_pre_pc", pc, 9'h060);
        call = 1'b1; load_addr = 9'h070;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("ar_pc", pc, 9'h000);
        check("ar_sp", sp, 3'd0);
        check("ar_unf", err_unf, 1'b0);
        check("ar_ovf", err_ovf, 1'b0);
        check("ar_empty", stack_empty, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        call = 1'b0;
        #1;
        check("ar_hold_pc", pc, 9'h000);
        step(1, 0, 0, 0, 9'h000); check("ar_after_pc", pc, 9'h001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
